// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM states, reset-cause codes
// and a width helper for the cycle counters.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_SEQ  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    CAUSE_MASTER = 2'b00,
    CAUSE_EXT    = 2'b01,
    CAUSE_SW     = 2'b10
  } rst_cause_t;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rst_in_sync.sv
// Multi-flop synchroniser for the external reset pin; the chain clears to 0
// so a master reset always looks like an active external reset.
module rst_in_sync
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [NUM_STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) chain_q <= '0;
    else     chain_q <= {chain_q[NUM_STAGES-2:0], d};
  end

  assign q = chain_q[NUM_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Reset controller: filters the external reset, merges the software request
// and releases NUM_CH active-low domain resets in order with hold and gap timing.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int NUM_CH     = 4,
  parameter int FILTER_CYC = 4,
  parameter int HOLD_CYC   = 16,
  parameter int GAP_CYC    = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ASYNC_RST_N,
  input  logic              SW_RST_REQ,
  output logic [NUM_CH-1:0] SYNC_RST,
  output logic              RST_DONE,
  output logic              BUSY,
  output logic [1:0]        RST_CAUSE
);

  localparam int FW = clog2_min1(FILTER_CYC + 1);
  localparam int HW = clog2_min1(HOLD_CYC + 1);
  localparam int GW = clog2_min1(GAP_CYC + 1);
  localparam int IW = clog2_min1(NUM_CH + 1);

  localparam logic [FW-1:0] FLT_LAST  = FW'(FILTER_CYC - 1);
  localparam logic [FW-1:0] FLT_SAT   = FW'(FILTER_CYC);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CH - 1);

  logic              synced;
  logic [FW-1:0]     flt_cnt_q, flt_cnt_d;
  logic              ext_req_q, ext_req_d;
  logic              ext_set, ext_now, ext_rise, sw_rise, req;
  logic              sw_q;

  seq_state_t        state_q, state_d;
  rst_cause_t        cause_q, cause_d;
  logic [NUM_CH-1:0] chan_q, chan_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [IW-1:0]     idx_q, idx_d;

  rst_in_sync #(
    .NUM_STAGES(NUM_STAGES)
  ) u_sync (
    .clk(CLK),
    .rst(RST),
    .d  (ASYNC_RST_N),
    .q  (synced)
  );

  // Glitch filter: the count saturates, so ext_set fires once per low episode.
  always_comb begin
    flt_cnt_d = flt_cnt_q;
    ext_req_d = ext_req_q;
    ext_set   = 1'b0;
    if (synced) begin
      flt_cnt_d = '0;
      ext_req_d = 1'b0;
    end else begin
      if (flt_cnt_q != FLT_SAT) flt_cnt_d = flt_cnt_q + FW'(1);
      if (flt_cnt_q == FLT_LAST) begin
        ext_set   = 1'b1;
        ext_req_d = 1'b1;
      end
    end
  end

  // The FSM reacts on the same edge the filter accepts a reset.
  assign ext_now  = ext_req_q | ext_set;
  assign ext_rise = ext_set & ~ext_req_q;
  assign sw_rise  = SW_RST_REQ & ~sw_q;
  assign req      = ext_now | SW_RST_REQ;

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    chan_d     = chan_q;
    done_d     = done_q;
    busy_d     = busy_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    idx_d      = idx_q;
    unique case (state_q)
      ST_HOLD: begin
        chan_d = '0;
        if (ext_rise || sw_rise) cause_d = ext_now ? CAUSE_EXT : CAUSE_SW;
        if (req) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          gap_cnt_d  = '0;
          chan_d[0]  = 1'b1;
          idx_d      = IW'(1);
          if (NUM_CH == 1) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_SEQ;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_SEQ: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          idx_d     = idx_q + IW'(1);
          for (int i = 0; i < NUM_CH; i++) begin
            if (idx_q == IW'(i)) chan_d[i] = 1'b1;
          end
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      ST_DONE: begin
      end
      default: state_d = ST_HOLD;
    endcase
    // A request outside HOLD re-asserts every channel at once.
    if (req && state_q != ST_HOLD) begin
      state_d    = ST_HOLD;
      cause_d    = ext_now ? CAUSE_EXT : CAUSE_SW;
      chan_d     = '0;
      done_d     = 1'b0;
      busy_d     = 1'b1;
      hold_cnt_d = '0;
      gap_cnt_d  = '0;
      idx_d      = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      flt_cnt_q  <= '0;
      ext_req_q  <= 1'b1;
      sw_q       <= 1'b0;
      state_q    <= ST_HOLD;
      cause_q    <= CAUSE_MASTER;
      chan_q     <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b1;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      idx_q      <= '0;
    end else begin
      flt_cnt_q  <= flt_cnt_d;
      ext_req_q  <= ext_req_d;
      sw_q       <= SW_RST_REQ;
      state_q    <= state_d;
      cause_q    <= cause_d;
      chan_q     <= chan_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      idx_q      <= idx_d;
    end
  end

  assign SYNC_RST  = chan_q;
  assign RST_DONE  = done_q;
  assign BUSY      = busy_q;
  assign RST_CAUSE = cause_q;

endmodule
